muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with early exit for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [4:0]          cnt_r;
  logic [2:0]          f_r;
  logic                neg_res_r, neg_rem_r, early_r;
  logic [2*XLEN-1:0]   acc_r, mcand_r, acc_nxt_s;
  logic [XLEN-1:0]     mplier_r;
  logic                busy_r, done_r;
  logic [XLEN-1:0]     result_r;
  logic                busy_nxt_s, done_nxt_s;
  logic [XLEN-1:0]     result_nxt_s;

  logic                accept_s, signed_a_s, signed_b_s, sign_a_s, sign_b_s;
  logic                div_zero_s, ovf_s, early_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s, early_res_s;
  logic [XLEN:0]       rem_sh_s;
  logic [XLEN-1:0]     diff_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, fin_s;

  assign accept_s    = (state_r == IDLE) && start && !flush;
  assign signed_a_s  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign signed_b_s  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sign_a_s    = signed_a_s && operand_a[XLEN-1];
  assign sign_b_s    = signed_b_s && operand_b[XLEN-1];
  assign mag_a_s     = sign_a_s ? -operand_a : operand_a;
  assign mag_b_s     = sign_b_s ? -operand_b : operand_b;
  assign div_zero_s  = funct3[2] && (operand_b == {XLEN{1'b0}});
  assign ovf_s       = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (operand_b == {XLEN{1'b1}});
  assign early_s     = div_zero_s || ovf_s;
  assign early_res_s = div_zero_s ? (funct3[1] ? operand_a : {XLEN{1'b1}})
                                  : (funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}});

  // One iteration: divide keeps {remainder, dividend/quotient} in acc_r, multiply accumulates.
  always_comb begin
    acc_nxt_s = acc_r;
    rem_sh_s  = acc_r[2*XLEN-1:XLEN-1];
    diff_s    = rem_sh_s[XLEN-1:0] - mcand_r[XLEN-1:0];
    if (f_r[2]) begin
      if (rem_sh_s >= {1'b0, mcand_r[XLEN-1:0]}) begin
        acc_nxt_s = {diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      if (mplier_r[0]) begin
        acc_nxt_s = acc_r + mcand_r;
      end else begin
        acc_nxt_s = acc_r;
      end
    end
  end

  // Sign fix-up and result select from the finished magnitudes.
  always_comb begin
    prod_s = neg_res_r ? -acc_r : acc_r;
    quo_s  = neg_res_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
    rem_s  = neg_rem_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
    case (f_r)
      3'b000:                 fin_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_s = quo_s;
      3'b110, 3'b111:         fin_s = rem_s;
      default:                fin_s = {XLEN{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = early_s ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == 5'd31) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: normal ops publish on leaving DONE, early exits publish at accept.
  always_comb begin
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    result_nxt_s = result_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          busy_nxt_s = 1'b1;
          if (early_s) begin
            done_nxt_s   = 1'b1;
            result_nxt_s = early_res_s;
          end else begin
            done_nxt_s   = 1'b0;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      RUN: busy_nxt_s = !flush;
      DONE: begin
        if (!early_r && !flush) begin
          busy_nxt_s   = 1'b1;
          done_nxt_s   = 1'b1;
          result_nxt_s = fin_s;
        end else begin
          busy_nxt_s   = 1'b0;
        end
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      result_r <= result_nxt_s;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 5'd0;
      f_r       <= 3'd0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      early_r   <= 1'b0;
      acc_r     <= {(2*XLEN){1'b0}};
      mcand_r   <= {(2*XLEN){1'b0}};
      mplier_r  <= {XLEN{1'b0}};
    end else if (accept_s) begin
      cnt_r     <= 5'd0;
      f_r       <= funct3;
      neg_res_r <= sign_a_s ^ sign_b_s;
      neg_rem_r <= sign_a_s;
      early_r   <= early_s;
      mcand_r   <= funct3[2] ? {{XLEN{1'b0}}, mag_b_s} : {{XLEN{1'b0}}, mag_a_s};
      acc_r     <= funct3[2] ? {{XLEN{1'b0}}, mag_a_s} : {(2*XLEN){1'b0}};
      mplier_r  <= funct3[2] ? {XLEN{1'b0}} : mag_b_s;
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r + 5'd1;
      acc_r <= acc_nxt_s;
      if (!f_r[2]) begin
        mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b, result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * $signed(ub); return p[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op in IDLE, then wait (bounded) for done and compare latency and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke_at);
    int n;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    funct3 = f; operand_a = a; operand_b = b; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    n = 1;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && n < 45) begin
      @(negedge clk);
      n++;
      if (n == poke_at) begin
        start = 1'b1; funct3 = 3'b101; operand_a = 32'd99; operand_b = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    if (exp_q.size() > 0) check_eq(tag, result, exp_q.pop_front());
    last_res = exp;
  endtask

  // Start an op, flush it after 'at' cycles, and confirm nothing is published.
  task automatic flush_op(input int at);
    int seen;
    @(negedge clk);
    funct3 = 3'b000; operand_a = 32'd12345; operand_b = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (at - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check_eq("flush_no_done", 32'(seen), 32'd0);
    check_eq("flush_result_kept", result, last_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
    last_res = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div",    3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34, 0);
    run_op("divu",   3'b101, 32'd20,         32'd3,         32'd6,         34, 0);
    run_op("remu",   3'b111, 32'd20,         32'd3,         32'd2,         34, 0);
    run_op("divu_z", 3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_z",  3'b110, 32'd5,          32'd0,         32'd5,         1,  0);
    run_op("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("poke",   3'b011, 32'h1234_5678,  32'h9ABC_DEF0, 32'h0B00_EA4E, 34, 5);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'(i);
      a = $urandom;
      b = (i == 6) ? 32'd0 : $urandom;
      run_op("rand", f, a, b, ref_model(f, a, b), (f[2] && b == 32'd0) ? 1 : 34, 0);
    end

    flush_op(11);
    run_op("post_flush", 3'b111, 32'd1000, 32'd7, 32'd6, 34, 0);

    @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = 3'b101; operand_a = 32'd9; operand_b = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check_eq("idle_flush_blocks", {31'd0, busy}, 32'd0);
    check_eq("idle_flush_nodone", {31'd0, done}, 32'd0);

    @(negedge clk);
    funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_result", result, 32'd0);
    last_res = 32'd0;

    run_op("post_rst", 3'b000, 32'd100, 32'd200, 32'd20000, 34, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
